// File: rtl/alu_seq.sv
// Registered ALU with start/done handshake; eight ops, iterative shift-add multiply.
// Build macro ALU_MUL_EN compiles in the multi-cycle multiplier; without it Op 111 returns zero.
module alu_seq #(
  parameter int WIDTH = 16
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Start,
  input  logic [2:0]       Op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] S,
  output logic             Z,
  output logic             C,
  output logic             V,
  output logic             Busy,
  output logic             Done
);

  // state    | meaning
  // ST_IDLE  | waiting for Start; single-cycle ops complete here
  // ST_MUL   | shift-add multiply, one multiplier bit per cycle

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  logic [WIDTH-1:0] s_q, s_d;
  logic             z_q, z_d;
  logic             c_q, c_d;
  logic             v_q, v_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c;
  logic             alu_v;

`ifdef ALU_MUL_EN
  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_sum;
`endif

  // Single-cycle datapath; Op 111 falls to the zero default and is handled by the FSM when enabled.
  always_comb begin
    sum     = {1'b0, A} + {1'b0, B};
    diff    = {1'b0, A} - {1'b0, B};
    shamt   = B[SHW-1:0];
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (Op)
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (A[WIDTH-1] == B[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff[WIDTH-1:0];
        alu_c   = diff[WIDTH];
        alu_v   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
      end
      OP_AND:  alu_res = A & B;
      OP_OR:   alu_res = A | B;
      OP_XOR:  alu_res = A ^ B;
      OP_SHL:  alu_res = A << shamt;
      OP_SHR:  alu_res = A >> shamt;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    s_d    = s_q;
    z_d    = z_q;
    c_d    = c_q;
    v_d    = v_q;
    done_d = 1'b0;
`ifdef ALU_MUL_EN
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_sum  = acc_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (Op == OP_MUL) begin
            state_d  = ST_MUL;
            mcand_d  = {{WIDTH{1'b0}}, A};
            mplier_d = B;
            acc_d    = '0;
            cnt_d    = '0;
          end else begin
            s_d    = alu_res;
            z_d    = (alu_res == '0);
            c_d    = alu_c;
            v_d    = alu_v;
            done_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
        // Last iteration writes straight from the adder so Done lands on the WIDTH-th edge.
        if (cnt_q == CNT_LAST) begin
          s_d     = acc_sum[WIDTH-1:0];
          z_d     = (acc_sum[WIDTH-1:0] == '0);
          c_d     = |acc_sum[2*WIDTH-1:WIDTH];
          v_d     = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`else
    if (Start) begin
      s_d    = alu_res;
      z_d    = (alu_res == '0);
      c_d    = alu_c;
      v_d    = alu_v;
      done_d = 1'b1;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      s_q    <= '0;
      z_q    <= 1'b1;
      c_q    <= 1'b0;
      v_q    <= 1'b0;
      done_q <= 1'b0;
`ifdef ALU_MUL_EN
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`endif
    end else begin
      s_q    <= s_d;
      z_q    <= z_d;
      c_q    <= c_d;
      v_q    <= v_d;
      done_q <= done_d;
`ifdef ALU_MUL_EN
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`endif
    end
  end

  assign S    = s_q;
  assign Z    = z_q;
  assign C    = c_q;
  assign V    = v_q;
  assign Done = done_q;
`ifdef ALU_MUL_EN
  assign Busy = (state_q == ST_MUL);
`else
  assign Busy = 1'b0;
`endif

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised-width ALU with a start/done handshake, superseding the 16-bit combinational ALU with a 1-bit opcode. It accepts operands and a 3-bit opcode on a single-cycle `Start` pulse, performs eight operations, and presents a registered result with status flags. Multiply is iterative shift-add and takes WIDTH cycles. It sits between the operand registers of the datapath and the result bus, paced by the controller through `Start`, `Busy` and `Done`.

## Interface
- `WIDTH`, default 16: operand and result width; power of two, at least 4.
- `Clk`  in  1  clock; all state changes on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `Start`  in  1  request; sampled only when `Busy`=0.
- `Op`  in  3  opcode, sampled with `Start`.
- `A`, `B`  in  WIDTH  operands, sampled with `Start`.
- `S`  out  WIDTH  result register.
- `Z`  out  1  result is zero.
- `C`  out  1  carry, borrow or multiply overflow.
- `V`  out  1  signed overflow.
- `Busy`  out  1  operation in progress; `Start` is ignored while high.
- `Done`  out  1  one-cycle pulse; `S`, `Z`, `C` and `V` were updated on the same edge.

## Operation
- Opcodes:
  - 000 ADD: A+B.
  - 001 SUB: A−B.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: A shifted left by B[log2(WIDTH)−1:0], zero fill.
  - 110 SHR: logical right shift by the same amount.
  - 111 MUL: low WIDTH bits of the unsigned product A×B.
- Shift amount is B modulo WIDTH. Upper bits of B are ignored.
- Flags are written only when `Done` pulses and hold otherwise.
  - Z = (S==0) for every opcode.
  - C:
    - ADD: carry-out.
    - SUB: borrow, i.e. A<B unsigned.
    - MUL: upper WIDTH bits of the full product are non-zero.
    - All other opcodes: 0.
  - V:
    - ADD/SUB: two's-complement overflow.
    - All other opcodes: 0.
- FSM states: IDLE, MUL.
  - IDLE, `Start`=1, Op≠111: compute the result and update outputs at the same edge, pulse `Done`, stay in IDLE.
  - IDLE, `Start`=1, Op=111: latch A and B, clear the accumulator and the iteration counter, go to MUL.
  - MUL: one multiplier bit per cycle, accumulator 2·WIDTH wide. After WIDTH iterations, write S/flags, pulse `Done`, go to IDLE.
- `Busy` = (state==MUL).
- `S` holds its value until the next `Done`.

## Timing
- Reset values: `S`=0, `Z`=1, `C`=0, `V`=0, `Busy`=0, `Done`=0, state IDLE, counter 0.
- Non-MUL ops: `Start` sampled at edge N; result and `Done`=1 are visible after edge N. Latency 1; throughput 1 per cycle with back-to-back `Start`.
- MUL: `Start` sampled at edge N.
  - `Busy`=1 after edge N.
  - Result, `Done`=1 and `Busy`=0 are visible after edge N+WIDTH.
- `Start` while `Busy`=1: ignored; no queuing, no effect on the operation in flight.
- `Start` in the cycle `Done`=1: accepted normally, since `Busy` is already 0.
- Operands may change freely after the accepting edge. MUL uses its latched copies.
- `Rst` has priority over everything. `Rst` during MUL aborts it: all outputs return to reset values on that edge, and no `Done` is produced.
- Counter wraps at exactly WIDTH iterations with no off-by-one. A×0 and 0×B still take the full WIDTH cycles.

## Configuration
- `ALU_MUL_EN` defined: MUL FSM, accumulator and counter are compiled in; Op 111 behaves as specified above.
- `ALU_MUL_EN` undefined: no MUL state or storage.
  - Op 111 completes in one cycle like the other ops, with S=0, Z=1, C=0, V=0.
  - `Busy` is tied 0.

## Test plan
- WIDTH=16, Rst then Op=000, A=10, B=12, one-cycle Start → next cycle S=22, Z=0, C=0, V=0, Done high for exactly 1 cycle.
- Op=001, A=5, B=7 → S=0xFFFE, C=1. Then Op=000, A=0x7FFF, B=1 → S=0x8000, V=1, C=0. Then A=0xFFFF, B=1 → S=0, Z=1, C=1.
- Op=101, A=1, B=17 → S=2. Op=110, A=0x8000, B=15 → S=1. Issue both on back-to-back Starts → two consecutive Done pulses.
- With ALU_MUL_EN: Op=111, A=300, B=300 → Busy for 16 cycles, then S=0x5F90, C=1, Done. A second Start with A=2, B=3 issued mid-operation is ignored, and S does not become 6.
- Rst asserted on the 8th cycle of a MUL → S=0, Z=1, Busy=0, no Done afterwards. Next Start with Op=111, A=7, B=9 → S=63, C=0 after 16 cycles.
- Without ALU_MUL_EN: Op=111, A=3, B=4 → 1-cycle Done with S=0, Z=1; Busy never asserts.
